stack_op_sequencer: RTL
=======================

# stack_op_sequencer

Sequences stack-touching instructions while they sit in the execute stage. It expands CALL, RET and RTI into their multi-cycle 16-bit memory access sequences and drives the ScndIteration and PrvsStackOp control bits that travel with the instruction into the memory stage. It also drives the stall that holds the front end and the ID/EX latch, and handles single-cycle PUSH/POP. It sits beside the execute stage and is fed by the decoded control bits of the instruction currently in ID/EX.

## Interface
- No parameters.
- CLK  in  1  pipeline clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high; forces IDLE and clears PrvsStackOp.
- Valid  in  1  ID/EX holds a live instruction.
- Flush  in  1  branch kill of the ID/EX instruction; honoured only in IDLE.
- CALL, RET, RTI, PUSH, POP  in  1 each  decoded control bits from ID/EX.
- MemBusy  in  1  memory stage cannot accept an access this cycle.
- Stall  out  1  hold PC, IF/ID and ID/EX this cycle.
- MemRd  out  1  stack read request this cycle.
- MemWr  out  1  stack write request this cycle.
- SP_Inc  out  1  commit SP+1 at the clock edge (pop).
- SP_Dec  out  1  commit SP−1 at the clock edge (push).
- HalfSel  out  1  PC half for this access: 0 = PC[15:0], 1 = PC[31:16].
- FlagsRestore  out  1  current pop loads the flags register (RTI only).
- ScndIteration  out  1  current access is the final half of a 32-bit PC transfer.
- PrvsStackOp  out  1  registered: the previous cycle committed an SP change.
- Busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, FLAGS, FIRST, SECOND.
- In IDLE, an operation is issued when Valid=1 and Flush=0. The state register moves to FLAGS, FIRST or SECOND only when MemBusy=0.
  - If more than one op bit is set, priority is RTI > RET > CALL > POP > PUSH.
  - Op bits are sampled only in IDLE. Later states ignore them, because ID/EX is held.
- All outputs except PrvsStackOp are Mealy functions of the state and inputs. The tables below are for MemBusy=0.
- PUSH, in IDLE: MemWr=1, SP_Dec=1, HalfSel=0, Stall=0. Stays in IDLE.
- POP, in IDLE: MemRd=1, SP_Inc=1, HalfSel=0, Stall=0. Stays in IDLE.
- CALL:
  - IDLE: MemWr, SP_Dec, HalfSel=0, Stall=1 → SECOND.
  - SECOND: MemWr, SP_Dec, HalfSel=1, ScndIteration=1, Stall=0 → IDLE.
- RET:
  - IDLE: MemRd, SP_Inc, HalfSel=1, Stall=1 → SECOND.
  - SECOND: MemRd, SP_Inc, HalfSel=0, ScndIteration=1, Stall=0 → IDLE.
- RTI:
  - IDLE: MemRd, SP_Inc, FlagsRestore=1, Stall=1 → FLAGS.
  - FLAGS: MemRd, SP_Inc, HalfSel=1, Stall=1 → FIRST.
  - FIRST: MemRd, SP_Inc, HalfSel=0, ScndIteration=1, Stall=0 → IDLE.
  - SECOND is not used by RTI.
- The state field is 2 bits. The op kind is latched in a 2-bit register on issue so that FLAGS/FIRST/SECOND can select read vs write and HalfSel.
- MemBusy=1 in any state, including IDLE with a pending stack op:
  - State holds.
  - MemRd/MemWr/HalfSel/FlagsRestore/ScndIteration keep their MemBusy=0 values, so the request stays asserted.
  - SP_Inc=SP_Dec=0, so nothing is committed.
  - Stall=1.
- Flush=1 in IDLE: all outputs 0 and no issue. Flush outside IDLE is ignored; the sequence completes.
- Valid=0, or no op bit set, in IDLE: all Mealy outputs 0.
- PrvsStackOp is set at the next edge to (SP_Inc | SP_Dec) and cleared otherwise.

## Timing
- Reset (sampled at an edge): state=IDLE, PrvsStackOp=0. With Valid=0, every output is 0 in the following cycle.
- Reset in mid-sequence aborts the sequence. No further SP commits occur after that edge.
- Latency with no MemBusy:
  - PUSH/POP: 1 cycle, no stall.
  - CALL/RET: 2 cycles, 1 stall cycle.
  - RTI: 3 cycles, 2 stall cycles.
- A new stack op may issue in the cycle immediately after a sequence returns to IDLE. There are no bubbles.
- PrvsStackOp lags the SP commit by exactly 1 cycle.

## Test plan
- **Reset:** drive Reset=1 for 2 cycles while Valid=1 and CALL=1 → Stall, MemWr and PrvsStackOp are all 0 during reset, and Busy=0. After release, CALL issues on the first cycle.
- **CALL, no MemBusy:** cycle 0 gives MemWr=1, SP_Dec=1, HalfSel=0, Stall=1. Cycle 1 gives HalfSel=1, ScndIteration=1, Stall=0. Cycle 2 is IDLE, with PrvsStackOp=1 in cycles 1 and 2.
- **RTI:** 3 cycles with FlagsRestore only in cycle 0 and HalfSel sequence x,1,0. ScndIteration is high only in cycle 2. SP_Inc is high in all 3 cycles.
- **RET with MemBusy=1 in its SECOND cycle for 2 cycles:** state holds and SP_Inc=0 during the busy cycles. Total SP_Inc pulses=2 and Stall is high for 3 cycles.
- **Back-to-back PUSH, PUSH, POP:** Stall stays 0 and SP_Dec,SP_Dec,SP_Inc occur on consecutive cycles. PrvsStackOp is 0,1,1,1.
- **Flush and priority:**
  - Flush=1 with RET in IDLE gives all outputs 0.
  - Flush=1 during CALL SECOND is ignored: ScndIteration=1.
  - CALL=RET=1 in IDLE executes RET.

Source files
------------

// File: rtl/stack_op_sequencer.sv
// Expands CALL/RET/RTI into 16-bit stack access sequences and handles single-cycle PUSH/POP.
// Ports: CLK/Reset (sync, active-high); Valid/Flush plus CALL/RET/RTI/PUSH/POP decoded from ID/EX;
// MemBusy backpressure; outputs: Stall, MemRd/MemWr, SP_Inc/SP_Dec, HalfSel, FlagsRestore, ScndIteration, PrvsStackOp, Busy.
module stack_op_sequencer (
  input  logic CLK,
  input  logic Reset,
  input  logic Valid,
  input  logic Flush,
  input  logic CALL,
  input  logic RET,
  input  logic RTI,
  input  logic PUSH,
  input  logic POP,
  input  logic MemBusy,
  output logic Stall,
  output logic MemRd,
  output logic MemWr,
  output logic SP_Inc,
  output logic SP_Dec,
  output logic HalfSel,
  output logic FlagsRestore,
  output logic ScndIteration,
  output logic PrvsStackOp,
  output logic Busy
);

  typedef enum logic [1:0] {IDLE, FLAGS, FIRST, SECOND} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_CALL, OP_RET, OP_RTI} op_t;

  state_t state, state_nxt, tgt;
  op_t    op_q, op_nxt, op_iss;
  logic   req;   // an access is requested this cycle
  logic   more;  // further accesses follow this one, so the front end must hold
  logic   rd, wr, half, flg, scnd;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= IDLE;
      op_q        <= OP_NONE;
      PrvsStackOp <= 1'b0;
    end else begin
      state       <= state_nxt;
      op_q        <= op_nxt;
      PrvsStackOp <= SP_Inc | SP_Dec;
    end
  end

  always_comb begin
    state_nxt     = state;
    op_nxt        = op_q;
    tgt           = state;
    op_iss        = op_q;
    req           = 1'b0;
    more          = 1'b0;
    rd            = 1'b0;
    wr            = 1'b0;
    half          = 1'b0;
    flg           = 1'b0;
    scnd          = 1'b0;
    Stall         = 1'b0;
    MemRd         = 1'b0;
    MemWr         = 1'b0;
    SP_Inc        = 1'b0;
    SP_Dec        = 1'b0;
    HalfSel       = 1'b0;
    FlagsRestore  = 1'b0;
    ScndIteration = 1'b0;

    unique case (state)
      IDLE: begin
        // Op bits are only looked at here; ID/EX is frozen for the rest of a sequence.
        if (Valid && !Flush) begin
          if (RTI) begin
            req = 1'b1; rd = 1'b1; flg = 1'b1; more = 1'b1;
            tgt = FLAGS; op_iss = OP_RTI;
          end else if (RET) begin
            // Return address is popped high half first.
            req = 1'b1; rd = 1'b1; half = 1'b1; more = 1'b1;
            tgt = SECOND; op_iss = OP_RET;
          end else if (CALL) begin
            // Return address is pushed low half first.
            req = 1'b1; wr = 1'b1; more = 1'b1;
            tgt = SECOND; op_iss = OP_CALL;
          end else if (POP) begin
            req = 1'b1; rd = 1'b1;
          end else if (PUSH) begin
            req = 1'b1; wr = 1'b1;
          end
        end
      end
      FLAGS: begin
        req = 1'b1; rd = 1'b1; half = 1'b1; more = 1'b1;
        tgt = FIRST;
      end
      FIRST: begin
        req = 1'b1; rd = 1'b1; scnd = 1'b1;
        tgt = IDLE; op_iss = OP_NONE;
      end
      SECOND: begin
        req  = 1'b1;
        scnd = 1'b1;
        if (op_q == OP_CALL) begin
          wr = 1'b1; half = 1'b1;
        end else begin
          rd = 1'b1;
        end
        tgt = IDLE; op_iss = OP_NONE;
      end
      default: begin
        tgt = IDLE; op_iss = OP_NONE;
      end
    endcase

    if (req) begin
      // The request stays visible while memory is busy; only the SP commit and advance wait.
      MemRd         = rd;
      MemWr         = wr;
      HalfSel       = half;
      FlagsRestore  = flg;
      ScndIteration = scnd;
      Stall         = more | MemBusy;
      if (!MemBusy) begin
        SP_Inc    = rd;
        SP_Dec    = wr;
        state_nxt = tgt;
        op_nxt    = op_iss;
      end
    end else if (state != IDLE) begin
      state_nxt = IDLE;
      op_nxt    = OP_NONE;
    end

    // A reset cycle must not commit anything or hold the front end.
    if (Reset) begin
      Stall         = 1'b0;
      MemRd         = 1'b0;
      MemWr         = 1'b0;
      SP_Inc        = 1'b0;
      SP_Dec        = 1'b0;
      HalfSel       = 1'b0;
      FlagsRestore  = 1'b0;
      ScndIteration = 1'b0;
    end
  end

  assign Busy = (state != IDLE);

endmodule
